// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers inst_mem words into a one-entry stage for decode.
// Latency: word at PC is presented as InstrValid the cycle after PC is driven; redirect target valid 2 cycles after BranchTaken.
// Backpressure: valid/ready; while the stage holds an unaccepted word, PC, InstrOut and PCOut all hold.
module fetch_ctrl #(
    parameter int unsigned MEM_BYTES = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] ReadAddr,
    input  logic [31:0] Instruccion,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] InstrOut,
    output logic [31:0] PCOut,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic        Halted,
    output logic        AddrErr,
    output logic [15:0] FetchCount
);

    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic [31:0] pcout_q, pcout_nxt;
    logic        vld_q, vld_nxt;
    logic        err_q, err_nxt;
    logic [15:0] cnt_q, cnt_nxt;

    logic        stage_free;
    logic        handshake;
    logic        capture;
    logic        tgt_bad;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr_q;
        pcout_nxt = pcout_q;
        vld_nxt   = vld_q;
        err_nxt   = err_q;
        cnt_nxt   = cnt_q;

        stage_free = !vld_q || InstrReady;
        handshake  = vld_q && InstrReady;
        capture    = (state == S_RUN) && stage_free && !BranchTaken;
        tgt_bad    = (BranchTarget[1:0] != 2'b00) || (BranchTarget >= MEM_LIMIT);

        // Counting is independent of redirect: a flushed-but-accepted word still reached decode.
        if (handshake && (state != S_BOOT) && (cnt_q != 16'hFFFF)) begin
            cnt_nxt = cnt_q + 16'd1;
        end

        case (state)
            S_BOOT:  state_nxt = S_RUN;
            S_RUN:   if (capture && (Instruccion == HALT_WORD)) state_nxt = S_HALT;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_BOOT;
        endcase

        if (BranchTaken) begin
            vld_nxt   = 1'b0;
            pc_nxt    = {BranchTarget[31:2], 2'b00} & ADDR_MASK;
            state_nxt = S_RUN;
            if (tgt_bad) begin
                err_nxt = 1'b1;
            end
        end else if (capture) begin
            instr_nxt = Instruccion;
            pcout_nxt = pc;
            vld_nxt   = 1'b1;
            pc_nxt    = (pc + 32'd4) & ADDR_MASK;
        end else if (handshake) begin
            vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_BOOT;
            pc      <= RESET_PC;
            instr_q <= 32'h0;
            pcout_q <= 32'h0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'h0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            instr_q <= instr_nxt;
            pcout_q <= pcout_nxt;
            vld_q   <= vld_nxt;
            err_q   <= err_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign ReadAddr   = pc;
    assign InstrOut   = instr_q;
    assign PCOut      = pcout_q;
    assign InstrValid = vld_q;
    assign Halted     = (state == S_HALT);
    assign AddrErr    = err_q;
    assign FetchCount = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational 8-word instruction memory model.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] ReadAddr;
    logic [31:0] Instruccion;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] InstrOut;
    logic [31:0] PCOut;
    logic        InstrValid;
    logic        InstrReady;
    logic        Halted;
    logic        AddrErr;
    logic [15:0] FetchCount;

    logic [31:0] mem [8];
    int total;
    int bad;

    fetch_ctrl #(
        .MEM_BYTES(32),
        .RESET_PC (32'h0),
        .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ReadAddr    (ReadAddr),
        .Instruccion (Instruccion),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .InstrOut    (InstrOut),
        .PCOut       (PCOut),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .Halted      (Halted),
        .AddrErr     (AddrErr),
        .FetchCount  (FetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign Instruccion = mem[ReadAddr[4:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) mem[i] = 32'h10 + 32'(i);
        rst_n = 1'b0; InstrReady = 1'b1; BranchTaken = 1'b0; BranchTarget = 32'h0;
        tick(); tick();
        total++;
        if ({InstrValid, InstrOut, PCOut, Halted, AddrErr, FetchCount, ReadAddr} !== {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0}) begin
            bad++;
            $display("FAIL reset_state: vld=%b instr=%h pc=%h halt=%b err=%b cnt=%0d addr=%h, want all zero",
                     InstrValid, InstrOut, PCOut, Halted, AddrErr, FetchCount, ReadAddr);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({InstrValid, ReadAddr} !== {1'b0, 32'h0}) begin
            bad++;
            $display("FAIL boot_cycle: vld=%b addr=%h, want vld=0 addr=0", InstrValid, ReadAddr);
        end
        tick();
        total++;
        if ({InstrValid, InstrOut, PCOut, ReadAddr} !== {1'b1, 32'h10, 32'h0, 32'h4}) begin
            bad++;
            $display("FAIL first_fetch: vld=%b instr=%h pc=%h addr=%h, want 1/10/0/4", InstrValid, InstrOut, PCOut, ReadAddr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp_pc = (32'(i) * 32'd4) % 32'd32;
            total++;
            if ({InstrValid, PCOut, InstrOut, FetchCount} !== {1'b1, exp_pc, 32'h10 + (exp_pc >> 2), 16'(i)}) begin
                bad++;
                $display("FAIL stream_%0d: vld=%b pc=%h instr=%h cnt=%0d, want pc=%h instr=%h cnt=%0d",
                         i, InstrValid, PCOut, InstrOut, FetchCount, exp_pc, 32'h10 + (exp_pc >> 2), i);
            end
        end
    endtask

    task automatic test_backpressure();
        tick();
        total++;
        if ({PCOut, ReadAddr, FetchCount} !== {32'h8, 32'hC, 16'd10}) begin
            bad++;
            $display("FAIL bp_setup: pc=%h addr=%h cnt=%0d, want 8/c/10", PCOut, ReadAddr, FetchCount);
        end
        InstrReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({InstrValid, InstrOut, PCOut, ReadAddr, FetchCount} !== {1'b1, 32'h12, 32'h8, 32'hC, 16'd10}) begin
                bad++;
                $display("FAIL bp_hold_%0d: vld=%b instr=%h pc=%h addr=%h cnt=%0d, want 1/12/8/c/10",
                         i, InstrValid, InstrOut, PCOut, ReadAddr, FetchCount);
            end
        end
        InstrReady = 1'b1;
        tick();
        total++;
        if ({InstrValid, InstrOut, PCOut, FetchCount} !== {1'b1, 32'h13, 32'hC, 16'd11}) begin
            bad++;
            $display("FAIL bp_resume: vld=%b instr=%h pc=%h cnt=%0d, want 1/13/c/11", InstrValid, InstrOut, PCOut, FetchCount);
        end
    endtask

    task automatic test_redirect();
        BranchTaken = 1'b1; BranchTarget = 32'd4;
        tick();
        BranchTaken = 1'b0;
        tick();
        total++;
        if ({InstrValid, PCOut, InstrOut, FetchCount} !== {1'b1, 32'h4, 32'h11, 16'd12}) begin
            bad++;
            $display("FAIL redir_to4: vld=%b pc=%h instr=%h cnt=%0d, want 1/4/11/12", InstrValid, PCOut, InstrOut, FetchCount);
        end
        InstrReady = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'd20;
        tick();
        total++;
        if ({InstrValid, ReadAddr, AddrErr, FetchCount} !== {1'b0, 32'd20, 1'b0, 16'd12}) begin
            bad++;
            $display("FAIL redir_flush: vld=%b addr=%h err=%b cnt=%0d, want 0/14/0/12", InstrValid, ReadAddr, AddrErr, FetchCount);
        end
        BranchTaken = 1'b0; InstrReady = 1'b1;
        tick();
        total++;
        if ({InstrValid, PCOut, InstrOut} !== {1'b1, 32'd20, 32'h15}) begin
            bad++;
            $display("FAIL redir_target: vld=%b pc=%h instr=%h, want 1/14/15", InstrValid, PCOut, InstrOut);
        end
        BranchTaken = 1'b1; BranchTarget = 32'd22;
        tick();
        total++;
        if ({InstrValid, ReadAddr, AddrErr, FetchCount} !== {1'b0, 32'd20, 1'b1, 16'd13}) begin
            bad++;
            $display("FAIL redir_misalign: vld=%b addr=%h err=%b cnt=%0d, want 0/14/1/13", InstrValid, ReadAddr, AddrErr, FetchCount);
        end
        BranchTaken = 1'b0;
        tick();
        total++;
        if ({InstrValid, PCOut, AddrErr} !== {1'b1, 32'd20, 1'b1}) begin
            bad++;
            $display("FAIL redir_misalign_tgt: vld=%b pc=%h err=%b, want 1/14/1", InstrValid, PCOut, AddrErr);
        end
    endtask

    task automatic test_halt();
        mem[3] = 32'hFFFF_FFFF;
        BranchTaken = 1'b1; BranchTarget = 32'd8;
        tick();
        BranchTaken = 1'b0;
        tick();
        tick();
        total++;
        if ({InstrValid, PCOut, InstrOut, Halted, ReadAddr} !== {1'b1, 32'd12, 32'hFFFF_FFFF, 1'b1, 32'd16}) begin
            bad++;
            $display("FAIL halt_deliver: vld=%b pc=%h instr=%h halt=%b addr=%h, want 1/c/ffffffff/1/10",
                     InstrValid, PCOut, InstrOut, Halted, ReadAddr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({InstrValid, Halted, ReadAddr, FetchCount} !== {1'b0, 1'b1, 32'd16, 16'd16}) begin
                bad++;
                $display("FAIL halt_hold_%0d: vld=%b halt=%b addr=%h cnt=%0d, want 0/1/10/16",
                         i, InstrValid, Halted, ReadAddr, FetchCount);
            end
        end
        mem[3] = 32'h13;
        BranchTaken = 1'b1; BranchTarget = 32'd0;
        tick();
        BranchTaken = 1'b0;
        total++;
        if ({InstrValid, Halted, ReadAddr} !== {1'b0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL halt_exit: vld=%b halt=%b addr=%h, want 0/0/0", InstrValid, Halted, ReadAddr);
        end
        tick();
        total++;
        if ({InstrValid, PCOut, InstrOut} !== {1'b1, 32'd0, 32'h10}) begin
            bad++;
            $display("FAIL halt_resume: vld=%b pc=%h instr=%h, want 1/0/10", InstrValid, PCOut, InstrOut);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        rst_n = 1'b0;
        tick();
        total++;
        if ({InstrValid, InstrOut, PCOut, Halted, AddrErr, FetchCount, ReadAddr} !== {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0}) begin
            bad++;
            $display("FAIL midreset_state: vld=%b instr=%h pc=%h halt=%b err=%b cnt=%0d addr=%h, want all zero",
                     InstrValid, InstrOut, PCOut, Halted, AddrErr, FetchCount, ReadAddr);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({InstrValid, ReadAddr} !== {1'b0, 32'h0}) begin
            bad++;
            $display("FAIL midreset_boot: vld=%b addr=%h, want 0/0", InstrValid, ReadAddr);
        end
        tick();
        total++;
        if ({InstrValid, InstrOut, PCOut, ReadAddr, FetchCount} !== {1'b1, 32'h10, 32'h0, 32'h4, 16'h0}) begin
            bad++;
            $display("FAIL midreset_fetch: vld=%b instr=%h pc=%h addr=%h cnt=%0d, want 1/10/0/4/0",
                     InstrValid, InstrOut, PCOut, ReadAddr, FetchCount);
        end
        BranchTaken = 1'b1; BranchTarget = 32'd32;
        tick();
        BranchTaken = 1'b0;
        total++;
        if ({AddrErr, ReadAddr} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL range_err: err=%b addr=%h, want 1/0", AddrErr, ReadAddr);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0; InstrReady = 1'b1; BranchTaken = 1'b0; BranchTarget = 32'h0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_redirect();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
